// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         NUM_VEC  = 8;
    localparam logic [2:0] LAST_IDX = 3'd7;

    // Golden truth table of F = ~C & (~A | B), bit i for {A,B,C} = i.
    localparam logic [7:0] F_TT = 8'h45;

endpackage

// File: rtl/tt_sweep_ctrl_func3_case.sv
// Purely combinational 3-input function unit under test: F = ~C & (~A | B).
module func3_case (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic F
);

    // Case-table form of the function, one row per input combination.
    always_comb begin
        F = 1'b0;
        case ({A, B, C})
            3'd0:    F = 1'b1;
            3'd2:    F = 1'b1;
            3'd6:    F = 1'b1;
            default: F = 1'b0;
        endcase
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps {A,B,C} through 0..7, holds each vector SETTLE cycles, captures F
// into a table and compares it against a latched golden table.
module tt_sweep_ctrl
    import tt_sweep_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] abc,
    output logic [7:0] table_out,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_fail_idx,
    output logic       first_fail_vld
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic [7:0] exp_lat;
    logic       f;
    logic       miss;

    func3_case u_func (
        .A (abc[2]),
        .B (abc[1]),
        .C (abc[0]),
        .F (f)
    );

    assign miss = (f != exp_lat[abc]);

    // pass is only meaningful while done is high, so decode it from DONE.
    assign pass = (state == DONE) && (mismatch_cnt == 4'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort wins over start in IDLE and over progress elsewhere.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = APPLY;
            APPLY: begin
                if (abort)                  state_nxt = IDLE;
                else if (settle_cnt == 4'd1) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort)                  state_nxt = IDLE;
                else if (abc == LAST_IDX)   state_nxt = DONE;
                else                        state_nxt = APPLY;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: vector index, settle timer, captured table and mismatch tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            abc            <= 3'd0;
            table_out      <= 8'h00;
            mismatch_cnt   <= 4'd0;
            first_fail_idx <= 3'd0;
            first_fail_vld <= 1'b0;
            settle_cnt     <= 4'd0;
        end else begin
            busy <= (state_nxt == APPLY) || (state_nxt == SAMPLE);
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (state_nxt == APPLY) begin
                        exp_lat        <= expected;
                        abc            <= 3'd0;
                        table_out      <= 8'h00;
                        mismatch_cnt   <= 4'd0;
                        first_fail_vld <= 1'b0;
                        settle_cnt     <= SETTLE_INIT;
                    end
                end
                APPLY: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                SAMPLE: begin
                    // The sample is recorded even when abort arrives in this cycle.
                    table_out[abc] <= f;
                    if (miss) begin
                        mismatch_cnt <= mismatch_cnt + 4'd1;
                        if (!first_fail_vld) begin
                            first_fail_idx <= abc;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (state_nxt == APPLY) begin
                        abc        <= abc + 3'd1;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench: stimulus pushes predicted sweep results, monitors pop on done.
module tb_tt_sweep_ctrl;

    typedef struct {
        logic [7:0] tbl;
        int         cnt;
        int         ffi;
        bit         ffv;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic [7:0] expected_a, expected_b;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [2:0] abc_a, ffi_a, abc_b, ffi_b;
    logic [7:0] tbl_a, tbl_b;
    logic [3:0] cnt_a, cnt_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    tt_sweep_ctrl #(.SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected(expected_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .abc(abc_a), .table_out(tbl_a), .mismatch_cnt(cnt_a),
        .first_fail_idx(ffi_a), .first_fail_vld(ffv_a)
    );

    tt_sweep_ctrl #(.SETTLE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected(expected_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .abc(abc_b), .table_out(tbl_b), .mismatch_cnt(cnt_b),
        .first_fail_idx(ffi_b), .first_fail_vld(ffv_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: evaluate the boolean function for every vector and compare.
    function automatic exp_t model(input logic [7:0] e, input int settle, input int k0);
        exp_t r;
        r.tbl = 8'h00; r.cnt = 0; r.ffi = 0; r.ffv = 0;
        for (int i = 0; i < 8; i++) begin
            bit a, b, c, fv;
            a = (i / 4) % 2 == 1;
            b = (i / 2) % 2 == 1;
            c = i % 2 == 1;
            fv = !c && (!a || b);
            r.tbl[i] = fv;
            if (fv != e[i]) begin
                r.cnt++;
                if (!r.ffv) begin r.ffv = 1; r.ffi = i; end
            end
        end
        r.due = k0 + 8 * (settle + 1);
        return r;
    endfunction

    // Monitor for the SETTLE=1 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_a) begin
                if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_done_time", cyc, e.due);
                    chk("a_table", tbl_a, e.tbl);
                    chk("a_mismatch", cnt_a, e.cnt);
                    chk("a_ffv", ffv_a, e.ffv);
                    if (e.ffv) chk("a_ffi", ffi_a, e.ffi);
                    chk("a_pass", pass_a, e.cnt == 0);
                end
            end else chk("a_pass_low", pass_a, 0);
        end
    end

    // Monitor for the SETTLE=4 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_b) begin
                if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_done_time", cyc, e.due);
                    chk("b_table", tbl_b, e.tbl);
                    chk("b_mismatch", cnt_b, e.cnt);
                    chk("b_ffv", ffv_b, e.ffv);
                    if (e.ffv) chk("b_ffi", ffi_b, e.ffi);
                    chk("b_pass", pass_b, e.cnt == 0);
                end
            end else chk("b_pass_low", pass_b, 0);
        end
    end

    task automatic start_sweep_a(input logic [7:0] e, input bit push);
        expected_a = e;
        start_a = 1'b1;
        if (push) qa.push_back(model(e, 1, cyc + 1));
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic start_sweep_b(input logic [7:0] e);
        expected_b = e;
        start_b = 1'b1;
        qb.push_back(model(e, 4, cyc + 1));
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_a_idle(input int budget);
        int n = 0;
        while ((busy_a || done_a) && n < budget) begin @(negedge clk); n++; end
        chk("a_idle_wait", n < budget, 1);
    endtask

    task automatic wait_b_idle(input int budget);
        int n = 0;
        while ((busy_b || done_b) && n < budget) begin @(negedge clk); n++; end
        chk("b_idle_wait", n < budget, 1);
    endtask

    task automatic wait_a_abc(input logic [2:0] v, input int budget);
        int n = 0;
        while (!(busy_a && abc_a == v) && n < budget) begin @(negedge clk); n++; end
        chk("a_abc_wait", n < budget, 1);
    endtask

    task automatic check_a_reset_vals();
        chk("rst_abc", abc_a, 0);
        chk("rst_table", tbl_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_ffi", ffi_a, 0);
        chk("rst_ffv", ffv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; expected_a = 0;
        start_b = 0; abort_b = 0; expected_b = 0;
        repeat (3) @(negedge clk);
        check_a_reset_vals();
        chk("rst_b_busy", busy_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stretched timing: each vector held SETTLE=4 cycles plus one sample cycle.
        start_sweep_b(8'h45);
        for (int n = 1; n <= 40; n++) begin
            chk("b_abc_hold", abc_b, (n - 1) / 5);
            chk("b_busy", busy_b, 1);
            @(negedge clk);
        end
        wait_b_idle(5);
        start_sweep_b(8'($urandom));
        wait_b_idle(50);

        // Pass sweep with per-cycle vector stepping.
        start_sweep_a(8'h45, 1);
        for (int n = 1; n <= 16; n++) begin
            chk("a_abc_step", abc_a, (n - 1) / 2);
            chk("a_busy", busy_a, 1);
            @(negedge clk);
        end
        @(negedge clk);
        chk("a_post_done", done_a, 0);
        chk("a_post_busy", busy_a, 0);
        chk("a_abc_hold7", abc_a, 7);

        // Fail sweep then random golden tables.
        start_sweep_a(8'hFF, 1);
        wait_a_idle(40);
        for (int r = 0; r < 4; r++) begin
            start_sweep_a(8'($urandom), 1);
            wait_a_idle(40);
        end

        // Abort during APPLY of vector 3.
        start_sweep_a(8'h45, 0);
        wait_a_abc(3'd3, 20);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_table", tbl_a, 8'h05);
        chk("abort_cnt", cnt_a, 0);
        chk("abort_abc", abc_a, 3);
        repeat (3) @(negedge clk);

        // Abort arriving in SAMPLE still records that sample.
        start_sweep_a(8'h00, 0);
        wait_a_abc(3'd2, 20);
        @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_s_busy", busy_a, 0);
        chk("abort_s_table", tbl_a, 8'h05);
        chk("abort_s_cnt", cnt_a, 2);
        chk("abort_s_ffi", ffi_a, 0);
        chk("abort_s_ffv", ffv_a, 1);

        // start together with abort in IDLE is ignored.
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        chk("start_abort_idle", busy_a, 0);

        // start held through DONE must not launch a sweep.
        begin
            int n = 0;
            start_sweep_a(8'h45, 1);
            while (!done_a && n < 40) begin @(negedge clk); n++; end
            chk("done_wait", n < 40, 1);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            chk("start_in_done", busy_a, 0);
            @(negedge clk);
            chk("start_in_done2", busy_a, 0);
        end
        start_sweep_a(8'h44, 1);
        wait_a_idle(40);

        // Reset mid-sweep at vector 5, then start on the first edge after release.
        start_sweep_a(8'h45, 0);
        wait_a_abc(3'd5, 20);
        rst_n = 1'b0;
        @(negedge clk);
        check_a_reset_vals();
        rst_n = 1'b1;
        start_sweep_a(8'h45, 1);
        chk("restart_busy", busy_a, 1);
        wait_a_idle(40);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
